apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  APB master stage that sits directly upstream of the team's APB memory slave.
//  Converts a simple valid/ready request port into APB setup/access transfers
//  (P_selx, P_enable, P_write, P_addr, P_wdata), then waits for P_ready.
//  Returns each completion as a one-cycle response pulse carrying read data and
//  error status. Handles one outstanding transfer at a time.
// PARAMETERS
//  ADDR_W          32  width of req_addr / P_addr
//  DATA_W          32  width of all data buses
//  TIMEOUT_CYCLES  16  max ACCESS cycles before forced error (APB_TIMEOUT_EN only)
//  TO_CNT_W         5  timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  P_clk      in   1       clock; all logic on the rising edge
//  P_rst      in   1       reset, asynchronous, active-low
//  req_valid  in   1       request present
//  req_ready  out  1       bridge can accept a request (IDLE only)
//  req_write  in   1       1 = write, 0 = read
//  req_addr   in   ADDR_W  transfer address
//  req_wdata  in   DATA_W  write data
//  rsp_valid  out  1       one-cycle completion pulse
//  rsp_rdata  out  DATA_W  read data (0 for writes)
//  rsp_err    out  1       slave error, or timeout
//  P_addr     out  ADDR_W  APB address
//  P_selx     out  1       APB select
//  P_enable   out  1       APB enable
//  P_write    out  1       APB direction
//  P_wdata    out  DATA_W  APB write data
//  P_ready    in   1       APB slave ready
//  P_slverr   in   1       APB slave error
//  P_rdata    in   DATA_W  APB read data
// BEHAVIOUR
//  Reset (P_rst=0, asynchronous):
//   - state=IDLE.
//   - All outputs 0, except req_ready=1 once reset is released.
//  FSM: IDLE -> SETUP -> ACCESS -> IDLE. All outputs are registered.
//  IDLE:
//   - req_ready=1, P_selx=0, P_enable=0.
//   - On req_valid&&req_ready, latch write/addr/wdata into P_write/P_addr/P_wdata
//     and go to SETUP.
//  SETUP (exactly one cycle):
//   - P_selx=1, P_enable=0, req_ready=0; next state is ACCESS.
//  ACCESS:
//   - P_selx=1, P_enable=1.
//   - Holds while P_ready=0 (wait states are unlimited unless APB_TIMEOUT_EN).
//   - On a posedge with P_ready=1: capture P_slverr into rsp_err; capture
//     P_rdata into rsp_rdata for reads (0 for writes).
//     Pulse rsp_valid for one cycle, clear P_selx/P_enable, go to IDLE.
//  P_addr/P_write/P_wdata stay stable from SETUP through the final ACCESS cycle.
//   They hold their last value in IDLE.
//  P_ready/P_slverr/P_rdata are ignored outside ACCESS.
//  Latency:
//   - Accept edge = E0; SETUP at E0..E1; ACCESS from E1.
//   - With P_ready=1 at E2, rsp_valid is high in the cycle after E2.
//   - Minimum 3 cycles per transfer; next accept is possible at E3.
//  Responses have no backpressure; the consumer must take rsp_valid immediately.
//  A request with req_valid high while req_ready=0 is not accepted and is not
//   lost; the requester holds it.
//  Reset mid-transfer: the bus drops at once (P_selx=P_enable=0), no rsp_valid
//   is generated, and the transfer is abandoned.
// CONFIGURATION
//  APB_TIMEOUT_EN defined:
//   - Counter clears on entry to ACCESS and increments each ACCESS cycle with
//     P_ready=0.
//   - When it reaches TIMEOUT_CYCLES: rsp_valid=1, rsp_err=1, rsp_rdata=0,
//     bus released, return to IDLE.
//   - P_ready=1 on the same edge takes priority: normal completion.
//  APB_TIMEOUT_EN undefined: no counter; ACCESS waits forever for P_ready.
// TESTING
//  Write: req addr=0x05 wdata=0xDEADBEEF, P_ready=1 in ACCESS
//   -> SETUP then ACCESS, P_addr=0x05 stable; rsp_valid 1 cycle, rsp_err=0.
//  Read: addr=0x05 returning P_rdata=0xDEADBEEF after 2 wait states
//   -> ACCESS lasts 3 cycles; rsp_rdata=0xDEADBEEF, rsp_err=0.
//  Slave error: read with P_slverr=1 at P_ready
//   -> rsp_err=1, rsp_rdata=P_rdata; next request accepted afterwards.
//  Back-to-back: req_valid held high for 2 requests
//   -> second accepted exactly 1 cycle after the first rsp_valid; P_selx low 1 cycle between.
//  Reset asserted during ACCESS
//   -> all outputs 0 asynchronously, no rsp_valid; req_ready=1 after release.
//  APB_TIMEOUT_EN, P_ready held 0
//   -> after 16 ACCESS cycles rsp_valid=1, rsp_err=1, P_selx=0.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Request/response and APB bus signals of apb_master_bridge.
// master = bridge side, slave = requester plus APB slave environment.
interface apb_master_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] P_addr;
  logic              P_selx;
  logic              P_enable;
  logic              P_write;
  logic [DATA_W-1:0] P_wdata;
  logic              P_ready;
  logic              P_slverr;
  logic [DATA_W-1:0] P_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output P_addr, P_selx, P_enable, P_write, P_wdata,
    input  P_ready, P_slverr, P_rdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  P_addr, P_selx, P_enable, P_write, P_wdata,
    output P_ready, P_slverr, P_rdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB master bridge: valid/ready request -> APB SETUP/ACCESS -> one-cycle response.
// Optional ACCESS wait-state timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TO_CNT_W       = 5
) (
  input  logic                P_clk,
  input  logic                P_rst,
  apb_master_bridge_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state;

  if (TO_CNT_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_bad_to_cnt_w
    $error("TO_CNT_W too narrow to hold TIMEOUT_CYCLES");
  end

`ifdef APB_TIMEOUT_EN
  logic [TO_CNT_W-1:0] to_cnt;
  logic                to_hit;

  // Counter holds the number of already-elapsed stalled cycles, so the
  // edge ending the TIMEOUT_CYCLES-th stalled cycle sees TIMEOUT_CYCLES-1.
  always_comb to_hit = (to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge P_clk or negedge P_rst) begin
    if (!P_rst) begin
      state         <= IDLE;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.P_addr    <= '0;
      bus.P_selx    <= 1'b0;
      bus.P_enable  <= 1'b0;
      bus.P_write   <= 1'b0;
      bus.P_wdata   <= '0;
`ifdef APB_TIMEOUT_EN
      to_cnt        <= '0;
`endif
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          bus.P_selx    <= 1'b0;
          bus.P_enable  <= 1'b0;
          if (bus.req_valid && bus.req_ready) begin
            bus.P_write   <= bus.req_write;
            bus.P_addr    <= bus.req_addr;
            bus.P_wdata   <= bus.req_wdata;
            bus.P_selx    <= 1'b1;
            bus.req_ready <= 1'b0;
            state         <= SETUP;
          end
        end

        SETUP: begin
          bus.P_enable <= 1'b1;
`ifdef APB_TIMEOUT_EN
          to_cnt       <= '0;
`endif
          state        <= ACCESS;
        end

        ACCESS: begin
          if (bus.P_ready) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= bus.P_slverr;
            bus.rsp_rdata <= bus.P_write ? '0 : bus.P_rdata;
            bus.P_selx    <= 1'b0;
            bus.P_enable  <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else if (to_hit) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= '0;
            bus.P_selx    <= 1'b0;
            bus.P_enable  <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end

        default: begin
          bus.P_selx   <= 1'b0;
          bus.P_enable <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge (default and APB_TIMEOUT_EN builds).
module tb_apb_master_bridge;

  logic P_clk;
  logic P_rst;
  int   n_cmp;
  int   n_bad;

  apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master_bridge #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(16),
    .TO_CNT_W(5)
  ) dut (
    .P_clk(P_clk),
    .P_rst(P_rst),
    .bus  (bus.master)
  );

  // {P_selx, P_enable, req_ready, rsp_valid}
  logic [3:0] ctl;
  assign ctl = {bus.P_selx, bus.P_enable, bus.req_ready, bus.rsp_valid};

  initial begin
    P_clk = 1'b0;
    forever #5 P_clk = ~P_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge P_clk);
    #1;
  endtask

  task automatic test_reset();
    P_rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.P_ready = 1'b0; bus.P_slverr = 1'b0; bus.P_rdata = '0;
    #2 P_rst = 1'b0;
    #1;
    n_cmp++; if (ctl !== 4'b0000) begin n_bad++; $display("FAIL rst_ctl: got %b want 0000", ctl); end
    n_cmp++; if ({bus.P_addr, bus.P_wdata, bus.rsp_rdata} !== 96'd0) begin n_bad++;
      $display("FAIL rst_data: addr %h wdata %h rdata %h want 0", bus.P_addr, bus.P_wdata, bus.rsp_rdata); end
    n_cmp++; if ({bus.P_write, bus.rsp_err} !== 2'b00) begin n_bad++;
      $display("FAIL rst_flags: got %b want 00", {bus.P_write, bus.rsp_err}); end
    tick(); tick();
    n_cmp++; if (ctl !== 4'b0000) begin n_bad++; $display("FAIL rst_held_ctl: got %b want 0000", ctl); end
    P_rst = 1'b1;
    tick();
    n_cmp++; if (ctl !== 4'b0010) begin n_bad++; $display("FAIL rst_release_ready: got %b want 0010", ctl); end
  endtask

  task automatic test_write();
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h05; bus.req_wdata = 32'hDEADBEEF;
    tick();
    n_cmp++; if (ctl !== 4'b1000) begin n_bad++; $display("FAIL wr_setup_ctl: got %b want 1000", ctl); end
    n_cmp++; if ({bus.P_write, bus.P_addr, bus.P_wdata} !== {1'b1, 32'h05, 32'hDEADBEEF}) begin n_bad++;
      $display("FAIL wr_setup_bus: w %b addr %h wdata %h want 1 05 deadbeef", bus.P_write, bus.P_addr, bus.P_wdata); end
    bus.req_valid = 1'b0;
    bus.P_ready = 1'b1; bus.P_rdata = 32'h11112222;
    tick();
    n_cmp++; if (ctl !== 4'b1100) begin n_bad++; $display("FAIL wr_access_ctl: got %b want 1100", ctl); end
    n_cmp++; if (bus.P_addr !== 32'h05) begin n_bad++; $display("FAIL wr_access_addr: got %h want 05", bus.P_addr); end
    tick();
    n_cmp++; if (ctl !== 4'b0011) begin n_bad++; $display("FAIL wr_done_ctl: got %b want 0011", ctl); end
    n_cmp++; if ({bus.rsp_err, bus.rsp_rdata} !== 33'd0) begin n_bad++;
      $display("FAIL wr_done_rsp: err %b rdata %h want 0 0", bus.rsp_err, bus.rsp_rdata); end
    bus.P_ready = 1'b0;
    tick();
    n_cmp++; if (ctl !== 4'b0010) begin n_bad++; $display("FAIL wr_pulse_end: got %b want 0010", ctl); end
  endtask

  task automatic test_read_wait();
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h05; bus.req_wdata = 32'h0;
    bus.P_ready = 1'b0; bus.P_slverr = 1'b1; bus.P_rdata = 32'hDEADBEEF;
    tick();
    n_cmp++; if ({ctl, bus.P_write} !== 5'b10000) begin n_bad++; $display("FAIL rd_setup: got %b want 10000", {ctl, bus.P_write}); end
    bus.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (ctl !== 4'b1100) begin n_bad++; $display("FAIL rd_access_%0d: got %b want 1100", i, ctl); end
      n_cmp++; if (bus.P_addr !== 32'h05) begin n_bad++; $display("FAIL rd_addr_%0d: got %h want 05", i, bus.P_addr); end
    end
    bus.P_ready = 1'b1; bus.P_slverr = 1'b0;
    tick();
    n_cmp++; if (ctl !== 4'b0011) begin n_bad++; $display("FAIL rd_done_ctl: got %b want 0011", ctl); end
    n_cmp++; if ({bus.rsp_err, bus.rsp_rdata} !== {1'b0, 32'hDEADBEEF}) begin n_bad++;
      $display("FAIL rd_done_rsp: err %b rdata %h want 0 deadbeef", bus.rsp_err, bus.rsp_rdata); end
    bus.P_ready = 1'b0;
  endtask

  task automatic test_slverr();
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h10;
    bus.P_ready = 1'b1; bus.P_slverr = 1'b1; bus.P_rdata = 32'h12345678;
    tick();
    bus.req_valid = 1'b0;
    tick(); tick();
    n_cmp++; if (ctl !== 4'b0011) begin n_bad++; $display("FAIL err_done_ctl: got %b want 0011", ctl); end
    n_cmp++; if ({bus.rsp_err, bus.rsp_rdata} !== {1'b1, 32'h12345678}) begin n_bad++;
      $display("FAIL err_done_rsp: err %b rdata %h want 1 12345678", bus.rsp_err, bus.rsp_rdata); end
    bus.P_slverr = 1'b0; bus.P_rdata = 32'h99999999;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h20; bus.req_wdata = 32'hA5A5A5A5;
    tick();
    n_cmp++; if ({ctl, bus.P_addr} !== {4'b1000, 32'h20}) begin n_bad++;
      $display("FAIL err_next_accept: ctl %b addr %h want 1000 20", ctl, bus.P_addr); end
    bus.req_valid = 1'b0;
    tick(); tick();
    n_cmp++; if ({ctl, bus.rsp_err, bus.rsp_rdata} !== {4'b0011, 1'b0, 32'h0}) begin n_bad++;
      $display("FAIL err_next_rsp: ctl %b err %b rdata %h want 0011 0 0", ctl, bus.rsp_err, bus.rsp_rdata); end
    bus.P_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.P_ready = 1'b1; bus.P_rdata = 32'hCAFEF00D;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h100; bus.req_wdata = 32'h0BADF00D;
    tick();
    n_cmp++; if ({ctl, bus.P_addr} !== {4'b1000, 32'h100}) begin n_bad++;
      $display("FAIL b2b_first_setup: ctl %b addr %h want 1000 100", ctl, bus.P_addr); end
    bus.req_write = 1'b0; bus.req_addr = 32'h104; bus.req_wdata = 32'h0;
    tick();
    n_cmp++; if ({ctl, bus.P_write, bus.P_addr} !== {4'b1100, 1'b1, 32'h100}) begin n_bad++;
      $display("FAIL b2b_first_access: ctl %b w %b addr %h want 1100 1 100", ctl, bus.P_write, bus.P_addr); end
    tick();
    n_cmp++; if (ctl !== 4'b0011) begin n_bad++; $display("FAIL b2b_first_rsp: got %b want 0011", ctl); end
    tick();
    n_cmp++; if ({ctl, bus.P_write, bus.P_addr} !== {4'b1000, 1'b0, 32'h104}) begin n_bad++;
      $display("FAIL b2b_second_setup: ctl %b w %b addr %h want 1000 0 104", ctl, bus.P_write, bus.P_addr); end
    bus.req_valid = 1'b0;
    tick();
    n_cmp++; if (ctl !== 4'b1100) begin n_bad++; $display("FAIL b2b_second_access: got %b want 1100", ctl); end
    tick();
    n_cmp++; if ({ctl, bus.rsp_rdata} !== {4'b0011, 32'hCAFEF00D}) begin n_bad++;
      $display("FAIL b2b_second_rsp: ctl %b rdata %h want 0011 cafef00d", ctl, bus.rsp_rdata); end
    bus.P_ready = 1'b0;
    tick();
    n_cmp++; if (ctl !== 4'b0010) begin n_bad++; $display("FAIL b2b_idle: got %b want 0010", ctl); end
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h30; bus.req_wdata = 32'h13572468;
    bus.P_ready = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    tick();
    n_cmp++; if (ctl !== 4'b1100) begin n_bad++; $display("FAIL rmid_access: got %b want 1100", ctl); end
    #2 P_rst = 1'b0;
    #1;
    n_cmp++; if (ctl !== 4'b0000) begin n_bad++; $display("FAIL rmid_async_ctl: got %b want 0000", ctl); end
    n_cmp++; if ({bus.P_write, bus.P_addr, bus.P_wdata} !== 65'd0) begin n_bad++;
      $display("FAIL rmid_async_bus: w %b addr %h wdata %h want 0", bus.P_write, bus.P_addr, bus.P_wdata); end
    bus.P_ready = 1'b1;
    tick();
    n_cmp++; if (ctl !== 4'b0000) begin n_bad++; $display("FAIL rmid_held: got %b want 0000", ctl); end
    P_rst = 1'b1; bus.P_ready = 1'b0;
    tick();
    n_cmp++; if (ctl !== 4'b0010) begin n_bad++; $display("FAIL rmid_release: got %b want 0010", ctl); end
    tick();
    n_cmp++; if (ctl !== 4'b0010) begin n_bad++; $display("FAIL rmid_no_rsp: got %b want 0010", ctl); end
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h44;
    bus.P_ready = 1'b0; bus.P_slverr = 1'b0; bus.P_rdata = 32'h77;
    tick();
    bus.req_valid = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      n_cmp++; if (ctl !== 4'b1100) begin n_bad++; $display("FAIL to_wait_%0d: got %b want 1100", i, ctl); end
    end
    tick();
    n_cmp++; if ({ctl, bus.rsp_err, bus.rsp_rdata} !== {4'b0011, 1'b1, 32'h0}) begin n_bad++;
      $display("FAIL to_fire: ctl %b err %b rdata %h want 0011 1 0", ctl, bus.rsp_err, bus.rsp_rdata); end
    bus.req_valid = 1'b1; bus.req_addr = 32'h48;
    tick();
    bus.req_valid = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      n_cmp++; if (ctl !== 4'b1100) begin n_bad++; $display("FAIL to_prio_wait_%0d: got %b want 1100", i, ctl); end
    end
    bus.P_ready = 1'b1;
    tick();
    n_cmp++; if ({ctl, bus.rsp_err, bus.rsp_rdata} !== {4'b0011, 1'b0, 32'h77}) begin n_bad++;
      $display("FAIL to_prio_done: ctl %b err %b rdata %h want 0011 0 77", ctl, bus.rsp_err, bus.rsp_rdata); end
    bus.P_ready = 1'b0;
  endtask
`else
  task automatic test_long_stall();
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h40;
    bus.P_ready = 1'b0; bus.P_slverr = 1'b0; bus.P_rdata = 32'h5A5A0000;
    tick();
    bus.req_valid = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++; if (ctl !== 4'b1100) begin n_bad++; $display("FAIL stall_wait_%0d: got %b want 1100", i, ctl); end
    end
    bus.P_ready = 1'b1;
    tick();
    n_cmp++; if ({ctl, bus.rsp_err, bus.rsp_rdata} !== {4'b0011, 1'b0, 32'h5A5A0000}) begin n_bad++;
      $display("FAIL stall_done: ctl %b err %b rdata %h want 0011 0 5a5a0000", ctl, bus.rsp_err, bus.rsp_rdata); end
    bus.P_ready = 1'b0;
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_back_to_back();
    test_reset_mid();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`else
    test_long_stall();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
